// File: rtl/write_back_if.sv
// MEM/WB boundary signals: MEM-stage inputs and register-file write port.
// master drives the MEM side and observes writeback; slave is the stage itself.
interface write_back_if;
    logic        stall;
    logic        flush;
    logic        valid_in;
    logic [31:0] data_in;
    logic [31:0] alu_result_in;
    logic [5:0]  opcode;
    logic        reg_write_in;
    logic        mem_to_reg_in;
    logic [4:0]  write_reg_in;
    logic [31:0] write_data_out;
    logic [4:0]  write_reg_out;
    logic        reg_write_out;
    logic [31:0] retired_count;

    modport master (
        output stall, flush, valid_in, data_in, alu_result_in, opcode,
               reg_write_in, mem_to_reg_in, write_reg_in,
        input  write_data_out, write_reg_out, reg_write_out, retired_count
    );

    modport slave (
        input  stall, flush, valid_in, data_in, alu_result_in, opcode,
               reg_write_in, mem_to_reg_in, write_reg_in,
        output write_data_out, write_reg_out, reg_write_out, retired_count
    );
endinterface

// File: rtl/write_back.sv
// Writeback stage: MEM/WB register, big-endian load extraction, retired-instruction counter.
// Latency: 1 cycle from MEM inputs to register-file write outputs.
// Backpressure: stall holds the register and counter; flush inserts a bubble and wins over stall.
module write_back (
    input  logic        clk,
    input  logic        rst_n,
    write_back_if.slave wb
);
    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;

    typedef struct packed {
        logic        valid;
        logic        reg_write;
        logic        mem_to_reg;
        logic [5:0]  opcode;
        logic [4:0]  write_reg;
        logic [31:0] alu_result;
        logic [31:0] data;
    } memwb_t;

    memwb_t      memwb_d, memwb_q;
    logic [31:0] retired_count_d, retired_count_q;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] load_data;

    always_comb begin
        memwb_d         = memwb_q;
        retired_count_d = retired_count_q;
        if (wb.flush) begin
            // Bubble: only the control bits matter, datapath fields are left as-is
            memwb_d.valid      = 1'b0;
            memwb_d.reg_write  = 1'b0;
            memwb_d.mem_to_reg = 1'b0;
        end else if (!wb.stall) begin
            memwb_d.valid      = wb.valid_in;
            memwb_d.reg_write  = wb.reg_write_in;
            memwb_d.mem_to_reg = wb.mem_to_reg_in;
            memwb_d.opcode     = wb.opcode;
            memwb_d.write_reg  = wb.write_reg_in;
            memwb_d.alu_result = wb.alu_result_in;
            memwb_d.data       = wb.data_in;
            if (wb.valid_in) begin
                retired_count_d = retired_count_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            memwb_q         <= '0;
            retired_count_q <= '0;
        end else begin
            memwb_q         <= memwb_d;
            retired_count_q <= retired_count_d;
        end
    end

    always_comb begin
        sel_byte = 8'h00;
        case (memwb_q.alu_result[1:0])
            2'd0:    sel_byte = memwb_q.data[31:24];
            2'd1:    sel_byte = memwb_q.data[23:16];
            2'd2:    sel_byte = memwb_q.data[15:8];
            default: sel_byte = memwb_q.data[7:0];
        endcase
        sel_half = memwb_q.alu_result[1] ? memwb_q.data[15:0] : memwb_q.data[31:16];

        case (memwb_q.opcode)
            OP_LB:   load_data = {{24{sel_byte[7]}}, sel_byte};
            OP_LBU:  load_data = {24'h0, sel_byte};
            OP_LH:   load_data = {{16{sel_half[15]}}, sel_half};
            OP_LHU:  load_data = {16'h0, sel_half};
            default: load_data = memwb_q.data;
        endcase
    end

    assign wb.write_data_out = memwb_q.mem_to_reg ? load_data : memwb_q.alu_result;
    assign wb.write_reg_out  = memwb_q.write_reg;
    assign wb.reg_write_out  = memwb_q.valid & memwb_q.reg_write & (memwb_q.write_reg != 5'd0);
    assign wb.retired_count  = retired_count_q;
endmodule
